// File: rtl/osd_overlay.sv
// osd_overlay: auto-centres a monochrome OSD bitmap on scandoubled video and blends it in
// with a fixed two-pixel latency on sync and colour alike.
module osd_overlay #(
  parameter int OSD_W = 256,
  parameter int OSD_H = 64,
  parameter int HCNT_WIDTH = 11,
  parameter int VCNT_WIDTH = 10,
  parameter logic [17:0] FG_COLOR = 18'h3FFFF,
  localparam int AW = $clog2(OSD_W * OSD_H / 8)
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ce_pix,
  input  logic          osd_enable,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic [5:0]    r_in,
  input  logic [5:0]    g_in,
  input  logic [5:0]    b_in,
  output logic          hs_out,
  output logic          vs_out,
  output logic [5:0]    r_out,
  output logic [5:0]    g_out,
  output logic [5:0]    b_out
);
  localparam int XW = $clog2(OSD_W);
  localparam int YW = $clog2(OSD_H);
  localparam logic [HCNT_WIDTH-1:0] WIN_W = HCNT_WIDTH'(OSD_W);
  localparam logic [VCNT_WIDTH-1:0] WIN_H = VCNT_WIDTH'(OSD_H);

  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] rd_data;
  logic [AW-1:0] rd_addr;
  logic hs_d, vs_d, hs_fall, vs_fall, osd_active, h_ok, v_ok, in_window;
  logic [HCNT_WIDTH-1:0] hcnt, hcnt_inc, h_total, h_start, hx;
  logic [VCNT_WIDTH-1:0] vcnt, vcnt_inc, v_total, v_start, vy;
  logic hs1, vs1, win1;
  logic [2:0] x1;
  logic [17:0] rgb1, px;

  assign hs_fall = hs_d & ~hs_in;
  assign vs_fall = vs_d & ~vs_in;
  assign hcnt_inc = &hcnt ? hcnt : hcnt + 1'b1;
  // A line edge is counted before a coincident frame edge latches the total.
  assign vcnt_inc = hs_fall && !(&vcnt) ? vcnt + 1'b1 : vcnt;
  assign hx = hcnt - h_start;
  assign vy = vcnt - v_start;
  assign in_window = osd_active && h_ok && v_ok && hcnt >= h_start && hx < WIN_W &&
                     vcnt >= v_start && vy < WIN_H;
  assign rd_addr = {vy[YW-1:0], hx[XW-1:3]};
  assign px = win1 ? (rd_data[~x1] ? FG_COLOR :
              {1'b0, rgb1[17:13], 1'b0, rgb1[11:7], 1'b0, rgb1[5:1]}) : rgb1;

  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (ce_pix) rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hs_d <= 1'b1;
      vs_d <= 1'b1;
      hcnt <= '0;
      vcnt <= '0;
      h_total <= '0;
      v_total <= '0;
      h_start <= '0;
      v_start <= '0;
      h_ok <= 1'b0;
      v_ok <= 1'b0;
      osd_active <= 1'b0;
    end else if (ce_pix) begin
      hs_d <= hs_in;
      vs_d <= vs_in;
      hcnt <= hs_fall ? '0 : hcnt_inc;
      vcnt <= vs_fall ? '0 : vcnt_inc;
      if (hs_fall) h_total <= hcnt;
      if (vs_fall) begin
        v_total <= vcnt_inc;
        osd_active <= osd_enable;
      end
      h_ok <= h_total >= WIN_W;
      v_ok <= v_total >= WIN_H;
      h_start <= (h_total - WIN_W) >> 1;
      v_start <= (v_total - WIN_H) >> 1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hs1 <= 1'b1;
      vs1 <= 1'b1;
      win1 <= 1'b0;
      x1 <= '0;
      rgb1 <= '0;
      hs_out <= 1'b1;
      vs_out <= 1'b1;
      {r_out, g_out, b_out} <= '0;
    end else if (ce_pix) begin
      hs1 <= hs_in;
      vs1 <= vs_in;
      win1 <= in_window;
      x1 <= hx[2:0];
      rgb1 <= {r_in, g_in, b_in};
      hs_out <= hs1;
      vs_out <= vs1;
      {r_out, g_out, b_out} <= px;
    end
  end
endmodule

// File: tb/tb_osd_overlay.sv
// tb_osd_overlay: directed frames with a scoreboard; expected pixels are queued at stimulus
// time and popped by an independent monitor two pixel clocks later.
`timescale 1ns/1ps
module tb_osd_overlay;
  logic clk_sys = 0, reset = 1, ce_pix = 1, osd_enable = 1, wr_en = 0;
  logic [10:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic hs_in = 1, vs_in = 1;
  logic [5:0] r_in = '0, g_in = '0, b_in = '0;
  logic hs_out, vs_out;
  logic [5:0] r_out, g_out, b_out;

  typedef struct { logic [19:0] v; int f; int l; int p; } ent_t;
  ent_t q[$];
  logic [7:0] bm [0:2047];
  logic [5:0] show_tab = 6'b010010;
  int checks = 0, failures = 0, frame_no = 0;
  bit show;

  osd_overlay dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .osd_enable(osd_enable),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .hs_in(hs_in), .vs_in(vs_in), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_out(hs_out), .vs_out(vs_out), .r_out(r_out), .g_out(g_out), .b_out(b_out)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  always @(posedge clk_sys)
    if (ce_pix && !reset && q.size() >= 2) begin
      ent_t e;
      #1;
      e = q.pop_front();
      chk($sformatf("f%0d_l%0d_p%0d", e.f, e.l, e.p),
          {hs_out, vs_out, r_out, g_out, b_out}, e.v);
    end

  // Window lands at line 1..64, pixel 2..257 for 260x66 timing (h_start=1, v_start=1).
  task automatic pix(input int l, input int p, input bit we, input bit rst);
    logic [5:0] r, b;
    logic [7:0] byt;
    logic [17:0] rgb;
    logic bt;
    int x;
    bit inw;
    ent_t e;
    @(negedge clk_sys);
    r = p[5:0];
    b = l[5:0];
    hs_in = p >= 16;
    vs_in = l >= 2;
    r_in = r;
    g_in = 6'h2A;
    b_in = b;
    ce_pix = 1;
    reset = rst;
    wr_en = we;
    wr_addr = '0;
    wr_data = 8'h7F;
    e.f = frame_no;
    e.l = l;
    e.p = p;
    if (rst) begin
      show = 0;
      q.delete();
      e.v = 20'hC0000;
      q.push_back(e);
    end else begin
      x = p - 2;
      inw = show && l >= 1 && l <= 64 && p >= 2 && p <= 257;
      bt = 0;
      if (inw) begin
        byt = bm[(l - 1) * 32 + x / 8];
        bt = byt[7 - x % 8];
      end
      rgb = !inw ? {r, 6'h2A, b} : bt ? 18'h3FFFF : {1'b0, r[5:1], 6'h15, 1'b0, b[5:1]};
      if (we) bm[0] = 8'h7F;
      e.v = {hs_in, vs_in, rgb};
      q.push_back(e);
    end
  endtask

  task automatic run_frame(input int nl, input int ll);
    show = show_tab[frame_no];
    for (int l = 0; l < nl; l++)
      for (int p = 0; p < ll; p++) begin
        if (l == 30 && p == 0 && (frame_no == 1 || frame_no == 2)) osd_enable = frame_no == 2;
        pix(l, p, frame_no == 1 && l == 1 && p == 2,
            frame_no == 4 && l == 20 && p >= 100 && p < 103);
      end
    frame_no++;
  endtask

  initial begin
    repeat (10) @(posedge clk_sys);
    #1;
    chk("reset_out", {hs_out, vs_out, r_out, g_out, b_out}, 20'hC0000);
    @(negedge clk_sys);
    reset = 0;
    ce_pix = 0;
    begin
      ent_t e;
      e.v = 20'hC0000;
      e.f = 0;
      e.l = -1;
      e.p = -1;
      q.push_back(e);
    end
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk_sys);
      wr_en = 1;
      wr_addr = i[10:0];
      wr_data = i == 0 ? 8'h80 : i == 31 ? 8'h01 : (i >= 32 && i < 1024) ? 8'hFF : 8'h00;
      bm[i] = wr_data;
    end
    run_frame(66, 260);
    run_frame(66, 260);
    run_frame(66, 260);
    run_frame(66, 200);
    run_frame(41, 260);
    run_frame(10, 260);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end
endmodule
